// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision format types and constants for the FP datapath.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} fpdiv_state_t;

    localparam int          FP_BIAS      = 127;
    localparam int          FP_EXP_MAX   = 255;
    localparam logic [31:0] FP_QNAN      = 32'h7FC00000;
    localparam int          FP_DIV_QBITS = 26;

endpackage

// File: rtl/fp_div_mant_core.sv
// fp_div_mant_core: radix-2 restoring divide of two 24-bit significands, one quotient bit per clock.
module fp_div_mant_core
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [25:0] q,
    output logic        rem_nz,
    output logic        done
);

    logic [24:0] rem_q, rem_d, rem_n;
    logic [23:0] div_q, div_d;
    logic [25:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [25:0] diff;
    logic        ge;

    // done marks the edge that produces the last quotient bit
    always_comb begin
        diff  = {1'b0, rem_q} - {2'b0, div_q};
        ge    = ~diff[25];
        rem_n = ge ? diff[24:0] : rem_q;
        done  = run_q && (cnt_q == 5'(FP_DIV_QBITS - 1));
        rem_d = rem_q;
        div_d = div_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            rem_d = {1'b0, ma};
            div_d = mb;
            q_d   = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = rem_n << 1;
            q_d   = {q_q[24:0], ge};
            cnt_d = cnt_q + 5'd1;
            run_d = ~done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            div_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign q      = q_q;
    assign rem_nz = rem_q != '0;

endmodule

// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE-754 single divider (subnormals flushed), truncating by default.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even.
module fp_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        busy
);

    fp32_t              fa, fb;
    logic               za, zb, ia, ib, na, nb, s;
    logic               is_nan, is_inf, is_zero, accept;
    fpdiv_state_t       state_q, state_d;
    logic               sign_q, sign_d, spec_q, spec_d;
    logic [31:0]        spec_res_q, spec_res_d, result_q, result_d;
    logic [9:0]         e_q, e_d;
    logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
    logic [25:0]        q;
    logic               rem_nz, core_done;
    logic [22:0]        mant, mant_r;
    logic               guard, sticky;
    logic signed [9:0]  e_n, e_r;
    logic [31:0]        norm_res;

    fp_div_mant_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .ma     ({1'b1, fa.man}),
        .mb     ({1'b1, fb.man}),
        .q      (q),
        .rem_nz (rem_nz),
        .done   (core_done)
    );

    always_comb begin
        fa      = A;
        fb      = B;
        za      = fa.exp == 8'd0;
        zb      = fb.exp == 8'd0;
        ia      = fa.exp == 8'(FP_EXP_MAX) && fa.man == 23'd0;
        ib      = fb.exp == 8'(FP_EXP_MAX) && fb.man == 23'd0;
        na      = fa.exp == 8'(FP_EXP_MAX) && fa.man != 23'd0;
        nb      = fb.exp == 8'(FP_EXP_MAX) && fb.man != 23'd0;
        s       = fa.sign ^ fb.sign;
        is_nan  = na | nb | (za & zb) | (ia & ib);
        is_inf  = ia | zb;
        is_zero = za | ib;
        accept  = in_valid && in_ready_q;
        // q[25] is the integer bit; without it the quotient is in [0.5,1)
        mant    = q[25] ? q[24:2] : q[23:1];
        guard   = q[25] ? q[1] : q[0];
        sticky  = rem_nz | (q[25] & q[0]);
        e_n     = q[25] ? $signed(e_q) : $signed(e_q) - 10'sd1;
    end

`ifdef FP_DIV_ROUND_NEAREST_EN
    logic [23:0] mant_sum;
    always_comb begin
        mant_sum = {1'b0, mant} + {23'd0, guard && (sticky || mant[0])};
        mant_r   = mant_sum[22:0];
        e_r      = e_n + (mant_sum[23] ? 10'sd1 : 10'sd0);
    end
`else
    logic round_unused;
    assign round_unused = guard ^ sticky;
    assign mant_r       = mant;
    assign e_r          = e_n;
`endif

    always_comb begin
        norm_res    = e_r >= $signed(10'(FP_EXP_MAX)) ? {sign_q, 8'hFF, 23'd0} :
                      e_r <= 10'sd0 ? {sign_q, 31'd0} : {sign_q, e_r[7:0], mant_r};
        state_d     = state_q;
        sign_d      = sign_q;
        spec_d      = spec_q;
        spec_res_d  = spec_res_q;
        e_d         = e_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (accept) begin
                sign_d     = s;
                e_d        = {2'b0, fa.exp} - {2'b0, fb.exp} + 10'(FP_BIAS);
                spec_d     = is_nan | is_inf | is_zero;
                spec_res_d = is_nan ? FP_QNAN : is_inf ? {s, 8'hFF, 23'd0} : {s, 31'd0};
                state_d    = spec_d ? NORM : DIVIDE;
            end
            DIVIDE: state_d = core_done ? NORM : DIVIDE;
            NORM: begin
                result_d    = spec_q ? spec_res_q : norm_res;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        in_ready_d = state_d == IDLE;
        busy_d     = state_d == DIVIDE || state_d == NORM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            e_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
            e_q         <= e_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vector table, randomized operands against an arithmetic reference, and handshake/reset sequences.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] Result;

    int n_cmp = 0;
    int n_bad = 0;

    fp_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r_trunc;
        logic [31:0] r_rne;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact quotient from wide integer division, then the format's rounding and range rules.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic  s, za, zb, ia, ib, na, nb, guard, sticky;
        int    e;
        longint ma, mb, full, rem, mant;
        s  = a[31] ^ b[31];
        za = a[30:23] == 8'd0;
        zb = b[30:23] == 8'd0;
        ia = a[30:23] == 8'hFF && a[22:0] == 0;
        ib = b[30:23] == 8'hFF && b[22:0] == 0;
        na = a[30:23] == 8'hFF && a[22:0] != 0;
        nb = b[30:23] == 8'hFF && b[22:0] != 0;
        if (na || nb || (za && zb) || (ia && ib)) return {1'b1, 32'h7FC00000};
        if (ia || zb) return {1'b1, s, 8'hFF, 23'd0};
        if (za || ib) return {1'b1, s, 31'd0};
        ma   = longint'({1'b1, a[22:0]});
        mb   = longint'({1'b1, b[22:0]});
        full = (ma << 36) / mb;
        rem  = (ma << 36) % mb;
        e    = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (full >= (64'sd1 <<< 36)) begin
            mant   = (full >> 13) & 64'h7FFFFF;
            guard  = full[12];
            sticky = (full[11:0] != 0) || rem != 0;
        end else begin
            mant   = (full >> 12) & 64'h7FFFFF;
            guard  = full[11];
            sticky = (full[10:0] != 0) || rem != 0;
            e      = e - 1;
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        if (guard && (sticky || mant[0])) mant = mant + 1;
        if (mant == 64'h800000) begin
            mant = 0;
            e    = e + 1;
        end
`else
        if (guard && sticky) mant = mant;
`endif
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), mant[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input string tag);
        int   lat;
        logic ir_bad, busy_bad;
        check({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        ir_bad   = 1'b0;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            ir_bad   |= in_ready;
            busy_bad |= ~busy;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_in_ready_low"}, {31'd0, ir_bad}, 32'd0);
        check({tag, "_busy_high"}, {31'd0, busy_bad}, 32'd0);
        check({tag, "_result"}, Result, exp_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_back_to_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    vec_t        vecs[14];
    logic [32:0] m;
    logic [31:0] ra, rb, held;

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 27};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 27};
        vecs[2]  = '{32'hC1000000, 32'h00000000, 32'hFF800000, 32'hFF800000, 1};
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 1};
        vecs[4]  = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 1};
        vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 1};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 27};
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 27};
        vecs[8]  = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 32'hC0400000, 27};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1};
        vecs[10] = '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 1};
        vecs[11] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 32'h80000000, 1};
        vecs[12] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 1};
        vecs[13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 27};

        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", Result, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
`ifdef FP_DIV_ROUND_NEAREST_EN
            run_op(vecs[i].a, vecs[i].b, vecs[i].r_rne, vecs[i].lat, $sformatf("vec%0d", i));
`else
            run_op(vecs[i].a, vecs[i].b, vecs[i].r_trunc, vecs[i].lat, $sformatf("vec%0d", i));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 7) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            m = ref_div(ra, rb);
            run_op(ra, rb, m[31:0], m[32] ? 1 : 27, $sformatf("rnd%0d_%h_%h", i, ra, rb));
        end

        A        = 32'h40C00000;
        B        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        held = Result;
        check("bp_result", held, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            A        = 32'h3F800000;
            B        = 32'h40400000;
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", i), {28'd0, out_valid, in_ready, busy, 1'b0}, 32'b1000);
            check($sformatf("bp_stable%0d", i), Result, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
        @(posedge clk); #1;
        check("bp_no_accept", {29'd0, out_valid, in_ready, busy}, 32'b010);

        A        = 32'h40C00000;
        B        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_result", Result, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 27, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 single-precision divider, Result = A / B.
- It is the inverse-operation companion to the team's combinational fp_multiplier and uses the same flushing conventions: subnormals are treated as zero, and the default rounding is truncation.
- The mantissa divide is radix-2 restoring, producing one quotient bit per clock.
- It sits behind a valid/ready operand channel and in front of a valid/ready result channel in the FP datapath.

Parameters:
- None. The number format is fixed; all format constants come from fp_pkg.

Ports:
- clk        input   1   rising-edge clock
- rst_n      input   1   asynchronous, active-low reset
- in_valid   input   1   A and B are valid
- in_ready   output  1   block accepts operands; high only in IDLE
- A          input   32  dividend, IEEE-754 single
- B          input   32  divisor, IEEE-754 single
- out_valid  output  1   Result is valid
- out_ready  input   1   consumer accepts Result
- Result     output  32  quotient, IEEE-754 single
- busy       output  1   high in DIVIDE or NORM

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - rst_n is asynchronous, active-low. Asserting it at any time, including mid-divide, clears all state: state=IDLE, out_valid=0, Result=0, busy=0, in_ready=1 after release.
  - No partial result survives a reset.
- Accept: operands are taken on the first clk edge where in_valid && in_ready (edge T). A and B are registered at that edge.
- State machine: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
  - IDLE, non-special operands: go to DIVIDE.
  - IDLE, special operands: go to NORM, with the special result preselected.
- Special-case classification at accept:
  - An operand with exp==0 counts as zero.
  - An operand with exp==255 and man!=0 is NaN.
  - Any NaN input, 0/0, or inf/inf: Result = 32'h7FC00000.
  - inf/x or x/0 (x finite, or inf/0): signed infinity {s,8'hFF,23'b0}.
  - 0/x or x/inf: signed zero {s,31'b0}.
  - s = sign_a ^ sign_b, including for zero and infinity results.
- Datapath for normal operands:
  - Exponent: e = exp_a - exp_b + 127, computed as a 10-bit signed value.
  - Mantissas: ma = {1,A[22:0]}, mb = {1,B[22:0]}.
  - Divide: restoring divide of ma by mb over exactly 26 cycles (DIVIDE state, edges T+1..T+26), producing q[25:0]. q[25] is the integer bit. A 5-bit counter controls the iteration.
  - Sticky bit: rem != 0.
- NORM (edge T+27):
  - If q[25]=1: mant = q[24:2], guard = q[1], sticky |= q[0].
  - Else: mant = q[23:1], guard = q[0], and e = e - 1.
  - If e >= 255: signed infinity.
  - If e <= 0: signed zero (no subnormal output).
  - Otherwise: {s, e[7:0], mant}.
  - Result is registered and out_valid is set.
- Latency: out_valid is high after edge T+27 for normal operands, and after edge T+1 for special cases.
- Output handshake (DONE):
  - Result and out_valid hold stable while out_ready=0.
  - On the edge with out_valid && out_ready, out_valid drops and the state returns to IDLE.
  - in_ready is low from T+1 until that return. There is no operand overlap, so throughput is one divide per 29 cycles at minimum.
- Simultaneous events: in_valid asserted while not in IDLE is ignored. The producer must hold its operands until in_ready.

Optional Feature:
- Macro: FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in NORM. Increment mant when guard && (sticky || mant[0]).
  - A carry out of mant sets mant=0 and e=e+1.
  - The overflow check to infinity is applied after rounding.
- Undefined: truncation (round toward zero). Guard and sticky are computed but unused. Behaviour matches fp_multiplier.

Decomposition:
- fp_pkg contains:
  - typedef fp32_t, a packed struct {sign, exp[7:0], man[22:0]}.
  - enum fpdiv_state_t {IDLE, DIVIDE, NORM, DONE}.
  - Constants FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000, FP_DIV_QBITS=26.
- Sub-module fp_div_mant_core: the iterative 24-bit restoring divider.
  - Inputs: start, ma, mb.
  - Outputs: q[25:0], rem_nz, done.
  - fp_divider holds the FSM, the special-case logic, and normalisation.

Test Plan:
- 6.0/2.0: A=40C00000, B=40000000 -> Result=40400000; out_valid exactly 27 edges after accept; in_ready low throughout.
- 1.0/3.0: A=3F800000, B=40400000 -> 3EAAAAAA without the macro; 3EAAAAAB with FP_DIV_ROUND_NEAREST_EN.
- Specials:
  - C1000000/00000000 -> FF800000, out_valid one edge after accept.
  - 0/0 -> 7FC00000.
  - 00000000/3F800000 -> 00000000.
  - 7F800000/7F800000 -> 7FC00000.
- Exponent limits:
  - 7F000000/3E800000 (e=256) -> 7F800000.
  - 00800000/40000000 (e=0) -> 00000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> Result stable, in_ready=0, second in_valid ignored; out_ready=1 -> the next edge returns to IDLE.
- Reset mid-divide: drop rst_n at iteration 10 -> out_valid=0 and Result=0 immediately (asynchronous); after release, a new 6.0/2.0 completes correctly.
